// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, status bit positions and FSM encodings for the
// TRSQ8 8N1 UART. The optional even-parity feature is enabled by defining
// UART_PARITY_EN; without it the PARITY states do not exist.
package uart_pkg;

  // Register select values (addr field decoded by uart_top)
  localparam logic [31:0] REG_DATA   = 32'd0;
  localparam logic [31:0] REG_STATUS = 32'd1;
  localparam logic [31:0] REG_DIV_L  = 32'd2;
  localparam logic [31:0] REG_DIV_H  = 32'd3;

  // STATUS register bit positions
  localparam int STAT_TX_BUSY    = 0;
  localparam int STAT_RX_VALID   = 1;
  localparam int STAT_OVERRUN    = 2;
  localparam int STAT_FRAME_ERR  = 3;
  localparam int STAT_PARITY_ERR = 4;

  // Oversampling: 16 ticks per bit, mid-bit sample on the 8th tick
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam logic [3:0] PHASE_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] PHASE_MID  = 4'(MID_SAMPLE - 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 2-FF synchronizer plus receive FSM. Emits a one-clk rx_done pulse
// with the byte and its error flags at the mid-point of the stop bit.
// Parity check present only when UART_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_done,
`ifdef UART_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err
);

  logic [1:0] sync;
  logic       rx_prev;
  rx_state_e  state, state_n;
  logic [3:0] phase, phase_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
`ifdef UART_PARITY_EN
  logic       par_bad, par_bad_n;
`endif

  logic rx_s;
  assign rx_s = sync[1];

  // State register, synchronizer and edge-detect history
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      sync    <= {sync[0], rxd};
      rx_prev <= rx_s;
      state   <= state_n;
      phase   <= phase_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
`ifdef UART_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  // Next-state logic: phase counts ticks, bits sampled mid-bit
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_n   = state;
    phase_n   = phase;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
`ifdef UART_PARITY_EN
    par_bad_n = par_bad;
`endif
    case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n = RX_START;
          phase_n = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          phase_n = phase + 4'd1;
          if (phase == PHASE_MID) begin
            if (rx_s) begin
              state_n = RX_IDLE;
            end else begin
              state_n   = RX_DATA;
              phase_n   = '0;
              bit_cnt_n = '0;
            end
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          phase_n = phase + 4'd1;
          if (phase == PHASE_LAST) begin
            shift_n   = {rx_s, shift[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              state_n = RX_PARITY;
`else
              state_n = RX_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          phase_n = phase + 4'd1;
          if (phase == PHASE_LAST) begin
            par_bad_n = rx_s ^ (^shift);
            state_n   = RX_STOP;
          end
        end
      end
`endif
      RX_STOP: begin
        if (tick) begin
          phase_n = phase + 4'd1;
          if (phase == PHASE_LAST) state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_done   = (state == RX_STOP) && tick && (phase == PHASE_LAST);
  assign rx_byte   = shift;
  assign frame_err = rx_done && !rx_s;
`ifdef UART_PARITY_EN
  assign parity_err = rx_done && par_bad;
`endif

endmodule

// File: rtl/uart_top.sv
// uart_top: register-mapped 8N1 UART (DATA/STATUS/DIV_L/DIV_H), tick
// generator, transmit FSM and register file; receive path in uart_rx.
// Define UART_PARITY_EN for even parity (11-bit frames, STATUS b4 live).
module uart_top
  import uart_pkg::*;
#(
  parameter int          ADDR_LSB          = 0,
  parameter int          OPT_MEM_ADDR_BITS = 1,
  parameter logic [15:0] DIV_RESET         = 16'd26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic       txd,
  input  logic       rxd
);

  logic [OPT_MEM_ADDR_BITS:0] sel;
  logic [31:0] reg_sel;
  logic        unused_addr;
  assign sel         = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign reg_sel     = 32'(sel);
  assign unused_addr = ^addr;

  logic [15:0] div, tick_cnt;
  logic        tick;
  logic [7:0]  rx_data;
  logic        rx_valid, overrun, frame_err;
`ifdef UART_PARITY_EN
  logic        parity_err, tx_par, rx_perr;
`endif

  tx_state_e  tx_state, tx_state_n;
  logic [3:0] tx_phase, tx_phase_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic       txd_n, tx_busy, tx_load;

  logic [7:0] rx_byte;
  logic       rx_done, rx_ferr;

  assign tick    = (tick_cnt == 16'd0);
  assign tx_busy = (tx_state != TX_IDLE);
  assign tx_load = wr_en && (reg_sel == REG_DATA) && !tx_busy;

  // Free-running baud tick counter; DIV changes land at the next reload
  always_ff @(posedge clk) begin
    if (!reset_n)  tick_cnt <= DIV_RESET;
    else if (tick) tick_cnt <= div;
    else           tick_cnt <= tick_cnt - 16'd1;
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_phase <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_phase <= tx_phase_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
`ifdef UART_PARITY_EN
      if (tx_load) tx_par <= ^din;
`endif
    end
  end

  // TX next-state: txd changes on phase 0, state advances on phase 15,
  // so the first tick after a load starts a full 16-tick start bit
  always_comb begin
    tx_state_n = tx_state;
    tx_phase_n = tx_phase;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    if (tx_state == TX_IDLE) begin
      txd_n = 1'b1;
      if (tx_load) begin
        tx_state_n = TX_START;
        tx_phase_n = '0;
        tx_bit_n   = '0;
        tx_shift_n = din;
      end
    end else if (tick) begin
      tx_phase_n = tx_phase + 4'd1;
      if (tx_phase == 4'd0) begin
        case (tx_state)
          TX_START:  txd_n = 1'b0;
          TX_DATA:   txd_n = tx_shift[0];
`ifdef UART_PARITY_EN
          TX_PARITY: txd_n = tx_par;
`endif
          default:   txd_n = 1'b1;
        endcase
      end
      if (tx_phase == PHASE_LAST) begin
        case (tx_state)
          TX_START: tx_state_n = TX_DATA;
          TX_DATA: begin
            tx_shift_n = tx_shift >> 1;
            tx_bit_n   = tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_state_n = TX_PARITY;
`else
              tx_state_n = TX_STOP;
`endif
            end
          end
`ifdef UART_PARITY_EN
          TX_PARITY: tx_state_n = TX_STOP;
`endif
          default: tx_state_n = TX_IDLE;
        endcase
      end
    end
  end

  uart_rx u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .rxd        (rxd),
    .rx_byte    (rx_byte),
    .rx_done    (rx_done),
`ifdef UART_PARITY_EN
    .parity_err (rx_perr),
`endif
    .frame_err  (rx_ferr)
  );

  logic       rd_clr, valid_eff;
  logic [7:0] w1c;
  assign rd_clr    = rd_en && (reg_sel == REG_DATA);
  assign valid_eff = rx_valid && !rd_clr;
  assign w1c       = (wr_en && (reg_sel == REG_STATUS)) ? din : 8'h00;

  // Register file: divisor, RX data/valid and sticky flags (set beats clear)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div        <= DIV_RESET;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (wr_en && reg_sel == REG_DIV_L) div[7:0]  <= din;
      if (wr_en && reg_sel == REG_DIV_H) div[15:8] <= din;
      if (rx_done && !valid_eff) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rd_clr) begin
        rx_valid <= 1'b0;
      end
      overrun    <= (overrun   && !w1c[STAT_OVERRUN])   || (rx_done && valid_eff);
      frame_err  <= (frame_err && !w1c[STAT_FRAME_ERR]) || rx_ferr;
`ifdef UART_PARITY_EN
      parity_err <= (parity_err && !w1c[STAT_PARITY_ERR]) || rx_perr;
`endif
    end
  end

  // Combinational read mux
  always_comb begin
    dout = 8'h00;
    case (reg_sel)
      REG_DATA: dout = rx_data;
      REG_STATUS: begin
        dout[STAT_TX_BUSY]    = tx_busy;
        dout[STAT_RX_VALID]   = rx_valid;
        dout[STAT_OVERRUN]    = overrun;
        dout[STAT_FRAME_ERR]  = frame_err;
`ifdef UART_PARITY_EN
        dout[STAT_PARITY_ERR] = parity_err;
`endif
      end
      REG_DIV_L: dout = div[7:0];
      REG_DIV_H: dout = div[15:8];
      default:   dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: directed self-checking bench for uart_top. Parity steps are
// compiled in when UART_PARITY_EN is defined.
module tb_uart_top;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] addr = '0, din = '0, dout;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic       txd, rxd, rxd_drv = 1'b1, loop = 1'b0;
  logic [7:0] v, exp_byte;
  int checks = 0, errors = 0;

  assign rxd = loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_top dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus tasks are entered on a falling edge
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    addr = a; rd_en = 1'b1;
    #1 d = dout;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    #1 d = dout;
  endtask

  task automatic wait_txd_fall(input string tag);
    int n = 0;
    while (txd !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {15'd0, txd}, 16'd0);
  endtask

  // Drive one frame on rxd at 64 clks per bit (DIV=3)
  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic flip_par);
    rxd_drv = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      wait_clks(64);
    end
`ifdef UART_PARITY_EN
    rxd_drv = (^b) ^ flip_par;
    wait_clks(64);
`endif
    rxd_drv = stop_bit;
    wait_clks(64);
    rxd_drv = 1'b1;
    wait_clks(64);
  endtask

  initial begin
    // Reset values
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(1);
    peek(8'h88, v); check("rst_data",   {8'd0, v}, 16'h0000);
    peek(8'h89, v); check("rst_status", {8'd0, v}, 16'h0000);
    peek(8'h8A, v); check("rst_div_l",  {8'd0, v}, 16'h001A);
    peek(8'h8B, v); check("rst_div_h",  {8'd0, v}, 16'h0000);
    check("rst_txd", {15'd0, txd}, 16'd1);

    // TX 0xA5 at DIV=3 (64 clks per bit), mid-frame write ignored
    wr(8'h8A, 8'h03);
    wr(8'h8B, 8'h00);
    peek(8'h8A, v); check("div_l_wr", {8'd0, v}, 16'h0003);
    wait_clks(40);
    wr(8'h88, 8'hA5);
    wait_txd_fall("tx_fall");
    wait_clks(32);
    check("tx_start_bit", {15'd0, txd}, 16'd0);
    peek(8'h89, v); check("tx_busy_start", {15'd0, v[0]}, 16'd1);
    wr(8'h88, 8'hFF);
    wait_clks(63);
    exp_byte = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_bit%0d", i), {15'd0, txd}, {15'd0, exp_byte[i]});
      wait_clks(64);
    end
`ifdef UART_PARITY_EN
    check("tx_par_a5", {15'd0, txd}, 16'd0);
    wait_clks(64);
`endif
    check("tx_stop_bit", {15'd0, txd}, 16'd1);
    peek(8'h89, v); check("tx_busy_stop", {15'd0, v[0]}, 16'd1);
    wait_clks(64);
    peek(8'h89, v); check("tx_busy_done", {8'd0, v}, 16'h0000);
    wait_clks(100);
    check("tx_no_replay", {15'd0, txd}, 16'd1);

    // Loopback single byte
    loop = 1'b1;
    wr(8'h88, 8'h3C);
    wait_clks(760);
    peek(8'h89, v); check("lb_valid", {8'd0, v}, 16'h0002);
    rd(8'h88, v);   check("lb_data",  {8'd0, v}, 16'h003C);
    peek(8'h89, v); check("lb_cleared", {8'd0, v}, 16'h0000);

    // Overrun: second byte dropped
    wr(8'h88, 8'h11);
    wait_clks(760);
    wr(8'h88, 8'h22);
    wait_clks(760);
    peek(8'h88, v); check("ovr_data",   {8'd0, v}, 16'h0011);
    peek(8'h89, v); check("ovr_status", {8'd0, v}, 16'h0006);
    wr(8'h89, 8'h04);
    peek(8'h89, v); check("ovr_w1c",    {8'd0, v}, 16'h0002);
    rd(8'h88, v);   check("ovr_read",   {8'd0, v}, 16'h0011);
    peek(8'h89, v); check("ovr_empty",  {8'd0, v}, 16'h0000);
    loop = 1'b0;

    // Frame error: stop bit held low, byte still delivered
    send_rx(8'h55, 1'b0, 1'b0);
    peek(8'h89, v); check("ferr_status", {8'd0, v}, 16'h000A);
    rd(8'h88, v);   check("ferr_data",   {8'd0, v}, 16'h0055);
    wr(8'h89, 8'h08);
    peek(8'h89, v); check("ferr_w1c",    {8'd0, v}, 16'h0000);

    // 4-clk glitch on idle line: no start
    rxd_drv = 1'b0;
    wait_clks(4);
    rxd_drv = 1'b1;
    wait_clks(100);
    peek(8'h89, v); check("glitch_status", {8'd0, v}, 16'h0000);

    // Clean externally driven frame
    send_rx(8'hC3, 1'b1, 1'b0);
    peek(8'h89, v); check("rx_c3_status", {8'd0, v}, 16'h0002);
    rd(8'h88, v);   check("rx_c3_data",   {8'd0, v}, 16'h00C3);

`ifdef UART_PARITY_EN
    // TX parity of 0x07 (three ones) is 1
    loop = 1'b1;
    wr(8'h88, 8'h07);
    wait_txd_fall("par_fall");
    wait_clks(32 + 64 * 9);
    check("tx_par_07", {15'd0, txd}, 16'd1);
    wait_clks(300);
    peek(8'h89, v); check("par_lb_status", {8'd0, v}, 16'h0002);
    rd(8'h88, v);   check("par_lb_data",   {8'd0, v}, 16'h0007);
    loop = 1'b0;
    // Flipped parity on RX
    send_rx(8'h5A, 1'b1, 1'b1);
    peek(8'h89, v); check("perr_status", {8'd0, v}, 16'h0012);
    rd(8'h88, v);   check("perr_data",   {8'd0, v}, 16'h005A);
    wr(8'h89, 8'h10);
    peek(8'h89, v); check("perr_w1c",    {8'd0, v}, 16'h0000);
`endif

    // Reset mid-TX
    wr(8'h88, 8'h00);
    wait_txd_fall("rst_tx_fall");
    wait_clks(100);
    check("rst_tx_low", {15'd0, txd}, 16'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1 check("rst_tx_txd", {15'd0, txd}, 16'd1);
    @(negedge clk);
    reset_n = 1'b1;
    peek(8'h89, v); check("rst_tx_status", {8'd0, v}, 16'h0000);
    peek(8'h8A, v); check("rst_tx_div",    {8'd0, v}, 16'h001A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
